traffic_light_monitor: RTL and testbench

//   Receive-side checker for the three-LED traffic-light drive (led0=RED, led1=YELLOW, led2=GREEN).

---
 rtl/traffic_light_monitor.sv | 126 ++++++++++++
 tb/tb_traffic_light_monitor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the RED/YELLOW/GREEN lamp drive: recovers the phase code and
// flags illegal patterns, illegal transitions and out-of-range phase dwell; counts full light cycles.
module traffic_light_monitor #(
  parameter int MIN_DWELL = 2,
  parameter int MAX_DWELL = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             led0,
  input  logic             led1,
  input  logic             led2,
  input  logic             err_clr,
  output logic [1:0]       state,
  output logic             state_valid,
  output logic             err_pattern,
  output logic             err_seq,
  output logic             err_dwell,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int DW_W = $clog2(MAX_DWELL + 2);
  localparam logic [DW_W-1:0] DW_SAT = DW_W'(MAX_DWELL + 1);
  localparam logic [DW_W-1:0] DW_MIN = DW_W'(MIN_DWELL);
  localparam logic [DW_W-1:0] DW_ONE = DW_W'(1);

  localparam logic [1:0] PH_RED = 2'd0;
  localparam logic [1:0] PH_Y1  = 2'd1;
  localparam logic [1:0] PH_GRN = 2'd2;
  localparam logic [1:0] PH_Y2  = 2'd3;

  typedef enum logic {SYNC = 1'b0, TRACK = 1'b1} mode_t;

  mode_t           mode, mode_nxt;
  logic [2:0]      led_q;
  logic            led_q_vld;
  logic [DW_W-1:0] dwell, dwell_nxt, dwell_inc;
  logic            first_ph, first_nxt;
  logic [1:0]      phase_nxt, obs;
  logic            ev_pattern, ev_seq, ev_dwell, cnt_inc;

  assign dwell_inc = dwell + DW_ONE;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      mode <= SYNC;
    end else begin
      mode <= mode_nxt;
    end
  end

  always_comb begin
    mode_nxt   = mode;
    phase_nxt  = state;
    dwell_nxt  = dwell;
    first_nxt  = first_ph;
    ev_pattern = 1'b0;
    ev_seq     = 1'b0;
    ev_dwell   = 1'b0;
    cnt_inc    = 1'b0;
    obs        = PH_RED;
    if (led_q_vld) begin
      if (!$onehot(led_q)) begin
        ev_pattern = 1'b1;
        mode_nxt   = SYNC;
      end else if (mode == SYNC) begin
        if (led_q == 3'b001) begin
          mode_nxt  = TRACK;
          phase_nxt = PH_RED;
          dwell_nxt = DW_ONE;
          first_nxt = 1'b1;
        end
      end else begin
        // A lit yellow is Y1 while still in the RED half of the cycle, Y2 in the GREEN half.
        if (led_q[0])      obs = PH_RED;
        else if (led_q[2]) obs = PH_GRN;
        else               obs = (state == PH_RED || state == PH_Y1) ? PH_Y1 : PH_Y2;

        if (obs == state) begin
          if (dwell != DW_SAT) begin
            dwell_nxt = dwell_inc;
            ev_dwell  = (dwell_inc == DW_SAT);
          end
        end else if (obs == state + 2'd1) begin
          ev_dwell  = (dwell < DW_MIN) && !first_ph;
          cnt_inc   = (state == PH_Y2);
          phase_nxt = obs;
          dwell_nxt = DW_ONE;
          first_nxt = 1'b0;
        end else begin
          ev_seq   = 1'b1;
          mode_nxt = SYNC;
        end
      end
    end
  end

  always_comb begin
    state_valid = (mode == TRACK);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      led_q       <= 3'b000;
      led_q_vld   <= 1'b0;
      state       <= PH_RED;
      dwell       <= '0;
      first_ph    <= 1'b0;
      err_pattern <= 1'b0;
      err_seq     <= 1'b0;
      err_dwell   <= 1'b0;
      cycle_cnt   <= '0;
    end else begin
      led_q       <= {led2, led1, led0};
      led_q_vld   <= 1'b1;
      state       <= phase_nxt;
      dwell       <= dwell_nxt;
      first_ph    <= first_nxt;
      err_pattern <= (err_pattern & ~err_clr) | ev_pattern;
      err_seq     <= (err_seq & ~err_clr) | ev_seq;
      err_dwell   <= (err_dwell & ~err_clr) | ev_dwell;
      if (cnt_inc) cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus randomized lamp sequences,
// every cycle compared against a ring-position reference model.
module tb_traffic_light_monitor;
  localparam int MIN_DWELL = 2;
  localparam int MAX_DWELL = 16;
  localparam int CNT_W     = 8;

  localparam logic [2:0] RED = 3'b001;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b100;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic led0 = 1'b0, led1 = 1'b0, led2 = 1'b0;
  logic err_clr = 1'b0;
  logic [1:0] state;
  logic state_valid, err_pattern, err_seq, err_dwell;
  logic [CNT_W-1:0] cycle_cnt;

  traffic_light_monitor #(.MIN_DWELL(MIN_DWELL), .MAX_DWELL(MAX_DWELL), .CNT_W(CNT_W)) dut (
    .clk(clk), .res(res), .led0(led0), .led1(led1), .led2(led2), .err_clr(err_clr),
    .state(state), .state_valid(state_valid), .err_pattern(err_pattern),
    .err_seq(err_seq), .err_dwell(err_dwell), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: position on the 4-step ring, plus lamp register seen by the monitor.
  logic [2:0] lq;
  bit lq_vld, m_track, m_first, m_pat, m_seq, m_dw;
  int m_phase, m_dwell, m_cnt;

  function automatic bit is_onehot(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  task automatic model_reset();
    lq = 3'b000; lq_vld = 0; m_track = 0; m_first = 0;
    m_pat = 0; m_seq = 0; m_dw = 0; m_phase = 0; m_dwell = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit clr);
    bit np, ns, nd;
    int seen;
    np = 0; ns = 0; nd = 0;
    if (lq_vld) begin
      if (!is_onehot(lq)) begin
        np = 1; m_track = 0;
      end else if (!m_track) begin
        if (lq == RED) begin
          m_track = 1; m_phase = 0; m_dwell = 1; m_first = 1;
        end
      end else begin
        seen = (lq == RED) ? 0 : (lq == GRN) ? 2 : ((m_phase < 2) ? 1 : 3);
        if (seen == m_phase) begin
          if (m_dwell < MAX_DWELL + 1) begin
            m_dwell++;
            if (m_dwell == MAX_DWELL + 1) nd = 1;
          end
        end else if (seen == (m_phase + 1) % 4) begin
          if (m_dwell < MIN_DWELL && !m_first) nd = 1;
          if (m_phase == 3) m_cnt = (m_cnt + 1) % (1 << CNT_W);
          m_phase = seen; m_dwell = 1; m_first = 0;
        end else begin
          ns = 1; m_track = 0;
        end
      end
    end
    m_pat = (m_pat && !clr) || np;
    m_seq = (m_seq && !clr) || ns;
    m_dw  = (m_dw && !clr) || nd;
  endtask

  task automatic compare_all();
    check("state", int'(state), m_phase);
    check("state_valid", int'(state_valid), int'(m_track));
    check("err_pattern", int'(err_pattern), int'(m_pat));
    check("err_seq", int'(err_seq), int'(m_seq));
    check("err_dwell", int'(err_dwell), int'(m_dw));
    check("cycle_cnt", int'(cycle_cnt), m_cnt);
  endtask

  // Inputs change at negedge; one rising edge; outputs compared at the following negedge.
  task automatic step(input logic [2:0] leds, input bit clr);
    {led2, led1, led0} = leds;
    err_clr = clr;
    @(posedge clk);
    model_step(clr);
    lq = leds; lq_vld = 1;
    @(negedge clk);
    compare_all();
  endtask

  task automatic hold(input logic [2:0] leds, input int n);
    repeat (n) step(leds, 1'b0);
  endtask

  task automatic do_reset();
    res = 1'b1;
    model_reset();
    @(negedge clk);
    compare_all();
    res = 1'b0;
  endtask

  initial begin
    int pos, dw, r;
    logic [2:0] ring [4];
    logic [2:0] pat;
    ring[0] = RED; ring[1] = YEL; ring[2] = GRN; ring[3] = YEL;

    repeat (2) @(negedge clk);
    do_reset();

    // Full legal cycle with valid dwells
    hold(RED, 4); hold(YEL, 3); hold(GRN, 5); hold(YEL, 3); hold(RED, 2);
    check("t1_cnt", int'(cycle_cnt), 1);
    check("t1_valid", int'(state_valid), 1);

    // RED -> GREEN is illegal, then relock on RED
    hold(GRN, 2);
    check("t2_seq", int'(err_seq), 1);
    check("t2_valid", int'(state_valid), 0);
    hold(RED, 3);
    check("t2_relock", int'(state_valid), 1);

    // Two lamps lit for one cycle, then clear
    hold(3'b011, 1);
    hold(RED, 1);
    check("t3_pat", int'(err_pattern), 1);
    step(RED, 1'b1);
    step(RED, 1'b0);
    check("t3_clr", int'(err_pattern), 0);

    // Overlong GREEN, then a one-cycle Y1
    hold(YEL, 3); hold(GRN, 17); hold(YEL, 2);
    check("t4_long", int'(err_dwell), 1);
    hold(RED, 3); step(RED, 1'b1);
    hold(YEL, 1); hold(GRN, 3);
    check("t4_short", int'(err_dwell), 1);
    hold(YEL, 2); hold(RED, 2); step(RED, 1'b1);

    // 256 legal cycles wrap the counter back to its starting value
    pos = int'(cycle_cnt);
    for (int c = 0; c < 256; c++) begin
      hold(YEL, 2); hold(GRN, 2); hold(YEL, 2); hold(RED, 2);
    end
    check("t5_wrap", int'(cycle_cnt), pos);
    hold(YEL, 2); hold(GRN, 2); hold(YEL, 1);
    res = 1'b1;
    #1;
    check("t5_rst_state", int'(state), 0);
    check("t5_rst_valid", int'(state_valid), 0);
    check("t5_rst_err", int'({err_pattern, err_seq, err_dwell}), 0);
    check("t5_rst_cnt", int'(cycle_cnt), 0);
    do_reset();

    // Clear coinciding with a new illegal move: the error wins
    hold(RED, 3);
    step(GRN, 1'b0);
    step(GRN, 1'b1);
    check("t6_seq", int'(err_seq), 1);
    step(RED, 1'b1);
    hold(RED, 2);

    // Randomized lamp traffic
    pos = 0;
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 19);
      dw = $urandom_range(1, MAX_DWELL + 2);
      if (r == 0) pat = 3'($urandom_range(0, 7));
      else if (r == 1) pat = ring[$urandom_range(0, 3)];
      else begin
        pos = (pos + 1) % 4;
        pat = ring[pos];
      end
      if (pat == RED) pos = 0;
      else if (pat == GRN) pos = 2;
      for (int i = 0; i < dw; i++) step(pat, ($urandom_range(0, 29) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
